// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    REDIRECT_WAIT = 2'd1,
    HALTED        = 2'd2
  } state_t;

  localparam int          DEF_WIDTH    = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam int          DEF_INC      = 2;
  localparam int          CNT_WIDTH    = 16;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Pipeline-side signal bundle of the PC redirect controller.
interface pc_redirect_ctrl_if
  import pc_redirect_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
  // Handshake: takeBranch qualifies branchTarget for one cycle (no back-pressure
  // on EX); fetch_stall is the fetch-side not-ready, so a new pc is taken only
  // on an edge where fetch_stall=0, otherwise the target is buffered.
  logic                 takeBranch;
  logic [WIDTH-1:0]     branchTarget;
  logic                 fetch_stall;
  logic                 hazard_stall;
  logic                 halt;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc_plus2;
  logic                 fetch_valid;
  logic                 flush_IFID;
  logic                 flush_IDEX;
  logic                 redirect_pending;
  logic                 halted;
  logic [CNT_WIDTH-1:0] redirect_cnt;
  state_t               state;

  modport master (
    output takeBranch, branchTarget, fetch_stall, hazard_stall, halt,
    input  pc, pc_plus2, fetch_valid, flush_IFID, flush_IDEX,
           redirect_pending, halted, redirect_cnt, state
  );

  modport slave (
    input  takeBranch, branchTarget, fetch_stall, hazard_stall, halt,
    output pc, pc_plus2, fetch_valid, flush_IFID, flush_IDEX,
           redirect_pending, halted, redirect_cnt, state
  );

endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module pc_redirect_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC generator: sequential increment, branch redirect with buffering
// while instruction memory is busy, and terminal HALT.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int               INC      = DEF_INC
) (
    input logic               clk,
    input logic               rst_n,
    pc_redirect_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    cnt_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.takeBranch) begin
          cnt_inc = 1'b1;
          if (!bus.fetch_stall) begin
            pc_d = bus.branchTarget;
          end else begin
            buf_d   = bus.branchTarget;
            state_d = REDIRECT_WAIT;
          end
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (!(bus.hazard_stall || bus.fetch_stall)) begin
          pc_d = pc_q + INC_W;
        end
      end
      // Memory still owns the old address; only fetch_stall and newer
      // redirects matter here, halt/hazard come from squashed instructions.
      REDIRECT_WAIT: begin
        if (bus.takeBranch) begin
          cnt_inc = 1'b1;
          if (!bus.fetch_stall) begin
            pc_d    = bus.branchTarget;
            state_d = RUN;
          end else begin
            buf_d = bus.branchTarget;
          end
        end else if (!bus.fetch_stall) begin
          pc_d    = buf_q;
          state_d = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  pc_redirect_ctrl_sat_counter #(
      .W(CNT_WIDTH)
  ) u_cnt (
      .clk  (clk),
      .clr_n(rst_n),
      .inc  (cnt_inc),
      .count(bus.redirect_cnt)
  );

  always_comb begin
    bus.pc               = pc_q;
    bus.pc_plus2         = pc_q + INC_W;
    bus.flush_IFID       = bus.takeBranch || (state_q == REDIRECT_WAIT);
    bus.flush_IDEX       = bus.takeBranch || (state_q == REDIRECT_WAIT);
    bus.fetch_valid      = (state_q == RUN) && !bus.takeBranch && !bus.fetch_stall;
    bus.redirect_pending = (state_q == REDIRECT_WAIT);
    bus.halted           = (state_q == HALTED);
    bus.state            = state_q;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic        fv;
    logic        fl;
    logic        pend;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   total;
  int   bad;

  pc_redirect_ctrl_if #(.WIDTH(16)) bus ();

  pc_redirect_ctrl #(
      .WIDTH   (16),
      .RESET_PC(16'h0000),
      .INC     (2)
  ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard helpers
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_plus2", bus.pc_plus2, e.pc + 16'd2);
      chk("fetch_valid", 16'(bus.fetch_valid), 16'(e.fv));
      chk("flush_IFID", 16'(bus.flush_IFID), 16'(e.fl));
      chk("flush_IDEX", 16'(bus.flush_IDEX), 16'(e.fl));
      chk("redirect_pending", 16'(bus.redirect_pending), 16'(e.pend));
      chk("halted", 16'(bus.halted), 16'(e.hlt));
      chk("redirect_cnt", bus.redirect_cnt, e.cnt);
    end
  end

  // driver: apply one cycle of inputs and push the outputs expected during it
  task automatic cyc(input logic rn, input logic tb, input logic [15:0] tgt,
                     input logic fs, input logic hz, input logic hl,
                     input logic [15:0] e_pc, input logic e_fv, input logic e_fl,
                     input logic e_pend, input logic e_hlt, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rn;
    bus.takeBranch   = tb;
    bus.branchTarget = tgt;
    bus.fetch_stall  = fs;
    bus.hazard_stall = hz;
    bus.halt         = hl;
    e = '{pc: e_pc, fv: e_fv, fl: e_fl, pend: e_pend, hlt: e_hlt, cnt: e_cnt};
    exp_q.push_back(e);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst_n            = 1'b0;
    bus.takeBranch   = 1'b0;
    bus.branchTarget = 16'h0000;
    bus.fetch_stall  = 1'b0;
    bus.hazard_stall = 1'b0;
    bus.halt         = 1'b0;
    repeat (2) @(posedge clk);

    // sequential fetch after reset
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'd0);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, 0, 0, 16'd0);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 0, 0, 0, 16'd0);
    // immediate redirects
    cyc(1, 1, 16'h0040, 0, 0, 0, 16'h0006, 0, 1, 0, 0, 16'd0);
    cyc(1, 1, 16'h000C, 0, 0, 0, 16'h0040, 0, 1, 0, 0, 16'd1);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h000C, 1, 0, 0, 0, 16'd2);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h000E, 1, 0, 0, 0, 16'd2);
    // redirect buffered behind 3 cycles of fetch_stall
    cyc(1, 1, 16'h0080, 1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'd2);
    cyc(1, 0, 16'h0000, 1, 0, 0, 16'h0010, 0, 1, 1, 0, 16'd3);
    cyc(1, 0, 16'h0000, 1, 0, 0, 16'h0010, 0, 1, 1, 0, 16'd3);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0010, 0, 1, 1, 0, 16'd3);
    // newer redirect overwrites buffer; halt/hazard ignored while waiting
    cyc(1, 1, 16'h00A0, 1, 0, 0, 16'h0080, 0, 1, 0, 0, 16'd3);
    cyc(1, 1, 16'h00C0, 1, 1, 1, 16'h0080, 0, 1, 1, 0, 16'd4);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0080, 0, 1, 1, 0, 16'd5);
    // redirect while waiting with memory free goes straight to pc
    cyc(1, 1, 16'h00D0, 1, 0, 0, 16'h00C0, 0, 1, 0, 0, 16'd5);
    cyc(1, 1, 16'h00E0, 0, 0, 0, 16'h00C0, 0, 1, 1, 0, 16'd6);
    // hazard and fetch stalls in RUN
    cyc(1, 0, 16'h0000, 0, 1, 0, 16'h00E0, 1, 0, 0, 0, 16'd7);
    cyc(1, 0, 16'h0000, 1, 0, 0, 16'h00E0, 0, 0, 0, 0, 16'd7);
    // branch beats halt and hazard in the same cycle
    cyc(1, 1, 16'h0100, 0, 1, 1, 16'h00E0, 0, 1, 0, 0, 16'd7);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0100, 1, 0, 0, 0, 16'd8);
    // halt alone, then everything ignored
    cyc(1, 0, 16'h0000, 0, 0, 1, 16'h0102, 1, 0, 0, 0, 16'd8);
    cyc(1, 1, 16'h0200, 0, 0, 0, 16'h0102, 0, 1, 0, 1, 16'd8);
    cyc(1, 0, 16'h0000, 1, 0, 0, 16'h0102, 0, 0, 0, 1, 16'd8);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0102, 0, 0, 0, 1, 16'd8);
    // reset out of HALTED, then wrap FFFE -> 0000
    cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0102, 0, 0, 0, 1, 16'd8);
    cyc(1, 1, 16'hFFFC, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'd0);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'hFFFC, 1, 0, 0, 0, 16'd1);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'hFFFE, 1, 0, 0, 0, 16'd1);
    // odd target loaded unmodified
    cyc(1, 1, 16'h1235, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'd1);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h1235, 1, 0, 0, 0, 16'd2);
    // reset during REDIRECT_WAIT discards the buffered 0200
    cyc(1, 1, 16'h0200, 1, 0, 0, 16'h1237, 0, 1, 0, 0, 16'd2);
    cyc(0, 0, 16'h0000, 1, 0, 0, 16'h1237, 0, 1, 1, 0, 16'd3);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'd0);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, 0, 0, 16'd0);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 0, 0, 0, 16'd0);

    // bulk redirects bring the counter to FFFD (unchecked cycles)
    @(posedge clk);
    #1;
    bus.takeBranch   = 1'b1;
    bus.branchTarget = 16'h0010;
    bus.fetch_stall  = 1'b0;
    bus.hazard_stall = 1'b0;
    bus.halt         = 1'b0;
    repeat (65532) @(posedge clk);

    // saturation at FFFF
    cyc(1, 1, 16'h0020, 0, 0, 0, 16'h0010, 0, 1, 0, 0, 16'hFFFD);
    cyc(1, 1, 16'h0030, 0, 0, 0, 16'h0020, 0, 1, 0, 0, 16'hFFFE);
    cyc(1, 1, 16'h0040, 0, 0, 0, 16'h0030, 0, 1, 0, 0, 16'hFFFF);
    cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0040, 1, 0, 0, 0, 16'hFFFF);

    @(negedge clk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-stage PC generator and redirect controller. It sits directly downstream of the EX-stage branch decision (takeBranch, branchTarget) and drives the instruction-memory fetch address. It also drives the IF/ID and ID/EX flush controls. A redirect that arrives while instruction memory is busy is buffered and applied once fetch can accept it. The block also handles HALT and counts redirects for performance monitoring.

Parameters:
WIDTH, 16, PC/address width.
RESET_PC, 16'h0000, PC value loaded at reset.
INC, 2, sequential PC increment (bytes per instruction).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
takeBranch  input  1  taken branch/jump resolved in EX this cycle.
branchTarget  input  WIDTH  redirect target; valid when takeBranch=1.
fetch_stall  input  1  instruction memory busy; the current fetch address must be held.
hazard_stall  input  1  ID-stage load-use stall; hold PC.
halt  input  1  HALT decoded in ID this cycle.
pc  output  WIDTH  current fetch address (registered).
pc_plus2  output  WIDTH  pc+INC, combinational, modulo 2^WIDTH.
fetch_valid  output  1  the instruction fetched at pc is on the correct path.
flush_IFID  output  1  squash the IF/ID pipeline register.
flush_IDEX  output  1  squash the ID/EX pipeline register.
redirect_pending  output  1  a buffered target is waiting (state REDIRECT_WAIT).
halted  output  1  processor halted.
redirect_cnt  output  16  saturating count of accepted redirects.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - pc=RESET_PC, state=RUN, target buffer=0, redirect_cnt=0.
  - halted=0, redirect_pending=0.
  - Reset wins over every other input, including mid-REDIRECT_WAIT; any buffered target is discarded.
- States: RUN, REDIRECT_WAIT, HALTED. Encoding is defined in the package.
- Combinational outputs:
  - flush_IFID = flush_IDEX = takeBranch | (state==REDIRECT_WAIT).
  - fetch_valid = (state==RUN) & ~takeBranch & ~fetch_stall.
  - redirect_pending = (state==REDIRECT_WAIT).
  - halted = (state==HALTED).
- RUN, priority order takeBranch > halt > stall > increment:
  - takeBranch & ~fetch_stall: pc<=branchTarget next edge (1-cycle redirect latency); redirect_cnt++.
  - takeBranch & fetch_stall: buffer<=branchTarget; pc held; state->REDIRECT_WAIT; redirect_cnt++.
  - halt (no takeBranch): state->HALTED; pc held. A halt in the same cycle as takeBranch is wrong-path and is ignored.
  - hazard_stall | fetch_stall: pc held. takeBranch overrides hazard_stall.
  - otherwise: pc<=pc+INC.
- REDIRECT_WAIT:
  - pc stays at the old address, because memory is still busy with it.
  - When fetch_stall falls: pc<=buffer; state->RUN on the same edge.
  - A further takeBranch in this state overwrites the buffer with the newest target and increments redirect_cnt. If fetch_stall is low in that same cycle, pc<=branchTarget directly.
  - halt and hazard_stall are ignored (wrong-path or bubble).
- HALTED:
  - Terminal until reset. pc held; fetch_valid=0.
  - takeBranch, halt and stalls are ignored; flushes follow the combinational rule above.
- Arithmetic:
  - pc+INC wraps modulo 2^WIDTH (e.g. FFFE -> 0000).
  - branchTarget is loaded unmodified; bit 0 is not forced.
  - redirect_cnt saturates at 16'hFFFF and never wraps.

Decomposition:
- Shared package: state typedef (RUN, REDIRECT_WAIT, HALTED), default RESET_PC and INC constants.
- One sub-module is natural: sat_counter (16-bit saturating increment with sync active-low clear), used for redirect_cnt.

Test Plan:
- Reset release, no stalls, 4 cycles -> pc 0000, 0002, 0004, 0006; fetch_valid=1; flushes=0; redirect_cnt=0.
- pc=0006, takeBranch=1, branchTarget=0040, fetch_stall=0 -> flush_IFID/IDEX=1 that cycle, fetch_valid=0; next cycle pc=0040, redirect_cnt=1.
- pc=0010, takeBranch=1, target=0080, fetch_stall=1 held 3 cycles -> redirect_pending=1 and pc=0010 for those cycles, flushes high throughout; edge after fetch_stall falls: pc=0080, redirect_pending=0.
- takeBranch=1 with halt=1 and hazard_stall=1 same cycle, target=0100 -> pc=0100, halted stays 0. Then a later halt alone -> halted=1, pc frozen; subsequent takeBranch ignored.
- pc=FFFE, no stalls -> next pc=0000. Force redirect_cnt to FFFE and issue 3 redirects -> count reads FFFF and holds.
- rst_n=0 asserted during REDIRECT_WAIT (buffer=0200) -> next edge pc=0000, redirect_pending=0, redirect_cnt=0; after release pc increments from 0000 and never reaches 0200.
